// File: rtl/pi_mem_arb.sv
// Cartridge memory port arbiter: CPU bus has default priority, the SPI PI bridge gets
// byte-lane steered slots, with an aging guarantee and a sticky overrun/timeout flag.
module pi_mem_arb #(
    parameter int PI_AGE = 4,
    parameter int PI_TMO = 24,
    parameter int AW     = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pi_sync,
    input  logic          pi_we,
    input  logic          pi_oe,
    input  logic [AW-1:0] pi_addr,
    input  logic [7:0]    pi_dato,
    output logic [7:0]    pi_dati,
    output logic          pi_busy,
    output logic          pi_err,
    input  logic          pi_err_clr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_dato,
    output logic          cpu_ack,
    output logic [15:0]   cpu_dati,
    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [AW-2:0] mem_addr,
    output logic [15:0]   mem_dato,
    input  logic          mem_ack,
    input  logic [15:0]   mem_dati
);

    // state | meaning
    // IDLE  | no access in flight, arbitration evaluated every cycle
    // CPU   | CPU access granted, mem_req raised the cycle after grant
    // PI    | PI byte access granted, mem_req raised the cycle after grant
    typedef enum logic [1:0] {S_IDLE, S_CPU, S_PI} state_t;

    localparam int AGE_W = $clog2(PI_AGE + 1);
    localparam int TMO_W = $clog2(PI_TMO + 1);

    state_t           state, state_nx;
    logic             grant_cpu, grant_pi, done, pi_done;
    logic             capture, overrun, tmo_hit;
    logic             pi_we_q;
    logic [AW-1:0]    pi_addr_q;
    logic [7:0]       pi_dat_q;
    logic [AGE_W-1:0] age;
    logic [TMO_W-1:0] tmo;
    logic             unused_bits;

    assign unused_bits = cpu_addr[0];

    always_comb begin
        state_nx  = state;
        grant_cpu = 1'b0;
        grant_pi  = 1'b0;
        done      = mem_req && mem_ack && (state != S_IDLE);
        pi_done   = done && (state == S_PI);
        capture   = pi_sync && (pi_we || pi_oe) && !pi_busy;
        overrun   = pi_sync && (pi_we || pi_oe) && pi_busy;
        tmo_hit   = pi_busy && !pi_done && (tmo == TMO_W'(PI_TMO - 1));
        case (state)
            S_IDLE: begin
                if (pi_busy && age == AGE_W'(PI_AGE)) begin
                    state_nx = S_PI;
                    grant_pi = 1'b1;
                end else if (cpu_req) begin
                    state_nx  = S_CPU;
                    grant_cpu = 1'b1;
                end else if (pi_busy) begin
                    state_nx = S_PI;
                    grant_pi = 1'b1;
                end
            end
            S_CPU, S_PI: begin
                if (done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pi_dati   <= '0;
            pi_busy   <= 1'b0;
            pi_err    <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_dati  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_dato  <= '0;
            pi_we_q   <= 1'b0;
            pi_addr_q <= '0;
            pi_dat_q  <= '0;
            age       <= '0;
            tmo       <= '0;
        end else begin
            state   <= state_nx;
            cpu_ack <= 1'b0;

            if (grant_cpu) begin
                mem_we   <= cpu_we;
                mem_be   <= cpu_be;
                mem_addr <= cpu_addr[AW-1:1];
                mem_dato <= cpu_dato;
            end
            // Big-endian lanes: even byte lives in [15:8]
            if (grant_pi) begin
                mem_we   <= pi_we_q;
                mem_be   <= pi_addr_q[0] ? 2'b01 : 2'b10;
                mem_addr <= pi_addr_q[AW-1:1];
                mem_dato <= {pi_dat_q, pi_dat_q};
            end

            if (done) mem_req <= 1'b0;
            else if (state != S_IDLE) mem_req <= 1'b1;

            if (done && state == S_CPU) begin
                cpu_ack  <= 1'b1;
                cpu_dati <= mem_dati;
            end

            if (pi_done) begin
                pi_busy <= 1'b0;
                if (!pi_we_q) pi_dati <= pi_addr_q[0] ? mem_dati[7:0] : mem_dati[15:8];
            end

            if (capture) begin
                pi_busy   <= 1'b1;
                pi_we_q   <= pi_we;
                pi_addr_q <= pi_addr;
                pi_dat_q  <= pi_dato;
                age       <= '0;
                tmo       <= '0;
            end else if (pi_busy) begin
                if (state != S_PI && age != AGE_W'(PI_AGE)) age <= age + AGE_W'(1);
                if (tmo != TMO_W'(PI_TMO)) tmo <= tmo + TMO_W'(1);
            end

            // Set beats clear when both land in the same cycle
            if (overrun || tmo_hit) pi_err <= 1'b1;
            else if (pi_err_clr) pi_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pi_mem_arb.sv
// Directed bench for pi_mem_arb: PI lane steering, read latency, aging, timeout,
// overrun and mid-transaction reset, against a behavioural wait-state memory.
module tb_pi_mem_arb;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          pi_sync, pi_we, pi_oe, pi_err_clr;
    logic [AW-1:0] pi_addr;
    logic [7:0]    pi_dato;
    logic [7:0]    pi_dati;
    logic          pi_busy, pi_err;
    logic          cpu_req, cpu_we;
    logic [1:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_dato;
    logic          cpu_ack;
    logic [15:0]   cpu_dati;
    logic          mem_req, mem_we;
    logic [1:0]    mem_be;
    logic [AW-2:0] mem_addr;
    logic [15:0]   mem_dato;
    logic          mem_ack = 1'b0;
    logic [15:0]   mem_dati = '0;

    int            n_checks = 0;
    int            n_fails  = 0;
    int            wait_cfg = 0;
    int            wcnt     = 0;
    int            cpu_ack_cnt = 0;
    logic [15:0]   mem_rd   = '0;
    logic [AW-2:0] txn_log[$];
    int            n0, a0;

    pi_mem_arb #(.PI_AGE(4), .PI_TMO(24), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .pi_sync(pi_sync), .pi_we(pi_we), .pi_oe(pi_oe), .pi_addr(pi_addr),
        .pi_dato(pi_dato), .pi_dati(pi_dati), .pi_busy(pi_busy), .pi_err(pi_err),
        .pi_err_clr(pi_err_clr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_dato(cpu_dato), .cpu_ack(cpu_ack), .cpu_dati(cpu_dati),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_dato(mem_dato), .mem_ack(mem_ack), .mem_dati(mem_dati)
    );

    always #5 clk = ~clk;

    // Memory acks after wait_cfg request cycles and logs the word address it served
    always @(posedge clk) begin
        #1;
        mem_ack = 1'b0;
        if (cpu_ack) cpu_ack_cnt++;
        if (mem_req) begin
            if (wcnt == wait_cfg) begin
                mem_ack  = 1'b1;
                mem_dati = mem_rd;
                txn_log.push_back(mem_addr);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy_low(input int max);
        for (int i = 0; i < max && pi_busy; i++) tick();
    endtask

    task automatic wait_cpu_ack(input int max);
        for (int i = 0; i < max && !cpu_ack; i++) tick();
    endtask

    initial begin
        rst = 1'b1; pi_sync = 0; pi_we = 0; pi_oe = 0; pi_err_clr = 0;
        pi_addr = '0; pi_dato = '0;
        cpu_req = 0; cpu_we = 0; cpu_be = '0; cpu_addr = '0; cpu_dato = '0;
        repeat (3) tick();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_pi_busy", 32'(pi_busy), 0);
        check("rst_pi_err", 32'(pi_err), 0);
        check("rst_pi_dati", 32'(pi_dati), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;
        tick();

        // PI write, odd byte, two wait states
        wait_cfg = 2;
        pi_sync = 1; pi_we = 1; pi_addr = 24'h000003; pi_dato = 8'hA5;
        tick();
        pi_sync = 0; pi_we = 0;
        check("wr_busy_set", 32'(pi_busy), 1);
        tick(); tick();
        check("wr_mem_req", 32'(mem_req), 1);
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_mem_be", 32'(mem_be), 32'h1);
        check("wr_mem_addr", 32'(mem_addr), 32'h1);
        check("wr_mem_dato", 32'(mem_dato), 32'hA5A5);
        tick(); tick();
        check("wr_ack_busy", 32'(pi_busy), 1);
        tick();
        check("wr_busy_fell", 32'(pi_busy), 0);
        check("wr_req_fell", 32'(mem_req), 0);
        check("wr_err", 32'(pi_err), 0);
        tick();

        // PI reads, zero-wait memory: even then odd byte
        wait_cfg = 0; mem_rd = 16'h1234;
        pi_sync = 1; pi_oe = 1; pi_addr = 24'h000010;
        tick();
        pi_sync = 0; pi_oe = 0;
        tick(); tick();
        check("rd0_mem_be", 32'(mem_be), 32'h2);
        check("rd0_mem_we", 32'(mem_we), 0);
        tick();
        check("rd0_pi_dati", 32'(pi_dati), 32'h12);
        check("rd0_busy", 32'(pi_busy), 0);
        tick();
        pi_sync = 1; pi_oe = 1; pi_addr = 24'h000011;
        tick();
        pi_sync = 0; pi_oe = 0;
        tick(); tick();
        check("rd1_mem_be", 32'(mem_be), 32'h1);
        check("rd1_dati_held", 32'(pi_dati), 32'h12);
        tick();
        check("rd1_pi_dati", 32'(pi_dati), 32'h34);
        tick();

        // Aging: continuous CPU stream with a PI read arriving alongside the first request
        n0 = txn_log.size(); a0 = cpu_ack_cnt;
        cpu_req = 1; cpu_we = 1; cpu_be = 2'b11; cpu_addr = 24'h000100; cpu_dato = 16'h5A5A;
        pi_sync = 1; pi_oe = 1; pi_addr = 24'h000020;
        tick();
        pi_sync = 0; pi_oe = 0;
        wait_busy_low(40);
        check("age_pi_done", 32'(pi_busy), 0);
        wait_cpu_ack(10);
        check("age_last_ack", 32'(cpu_ack), 1);
        cpu_req = 0;
        tick();
        check("age_txn_count", 32'(txn_log.size() - n0), 4);
        check("age_txn0_cpu", 32'(txn_log[n0]), 32'h80);
        check("age_txn1_cpu", 32'(txn_log[n0+1]), 32'h80);
        check("age_txn2_pi", 32'(txn_log[n0+2]), 32'h10);
        check("age_txn3_cpu", 32'(txn_log[n0+3]), 32'h80);
        check("age_ack_count", 32'(cpu_ack_cnt - a0), 3);
        tick();

        // Timeout: 30-cycle stall on a PI write
        wait_cfg = 30;
        pi_sync = 1; pi_we = 1; pi_addr = 24'h000040; pi_dato = 8'h3C;
        tick();
        pi_sync = 0; pi_we = 0;
        repeat (23) tick();
        check("tmo_not_yet", 32'(pi_err), 0);
        tick();
        check("tmo_err_set", 32'(pi_err), 1);
        check("tmo_still_busy", 32'(pi_busy), 1);
        wait_busy_low(60);
        check("tmo_completed", 32'(pi_busy), 0);
        check("tmo_err_sticky", 32'(pi_err), 1);
        pi_err_clr = 1;
        tick();
        pi_err_clr = 0;
        check("tmo_err_clr", 32'(pi_err), 0);
        tick();

        // Overrun, with a clear landing on the same cycle as the set
        wait_cfg = 1; n0 = txn_log.size();
        pi_sync = 1; pi_oe = 1; pi_addr = 24'h000080;
        tick();
        pi_oe = 0; pi_we = 1; pi_addr = 24'h000200; pi_err_clr = 1;
        tick();
        pi_sync = 0; pi_we = 0; pi_err_clr = 0;
        check("ovr_err_set", 32'(pi_err), 1);
        wait_busy_low(20);
        repeat (3) tick();
        check("ovr_one_txn", 32'(txn_log.size() - n0), 1);
        check("ovr_first_addr", 32'(txn_log[n0]), 32'h40);

        // Reset while a CPU access is in flight with a PI request pending
        wait_cfg = 10; a0 = cpu_ack_cnt;
        cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 24'h000101;
        pi_sync = 1; pi_oe = 1; pi_addr = 24'h000030;
        tick();
        pi_sync = 0; pi_oe = 0;
        tick();
        check("rstx_req_up", 32'(mem_req), 1);
        check("rstx_pi_pend", 32'(pi_busy), 1);
        rst = 1;
        tick();
        check("rstx_req_drop", 32'(mem_req), 0);
        check("rstx_no_ack", 32'(cpu_ack), 0);
        check("rstx_pi_clr", 32'(pi_busy), 0);
        rst = 0; wait_cfg = 0; mem_rd = 16'hBEEF; n0 = txn_log.size();
        wait_cpu_ack(10);
        check("rstx_fresh_ack", 32'(cpu_ack), 1);
        check("rstx_cpu_dati", 32'(cpu_dati), 32'hBEEF);
        cpu_req = 0;
        check("rstx_ack_count", 32'(cpu_ack_cnt - a0), 1);
        check("rstx_addr", 32'(txn_log[n0]), 32'h80);
        repeat (3) tick();
        check("rstx_no_pi_txn", 32'(txn_log.size() - n0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
